// File: rtl/vc_input_unit.sv
// vc_input_unit: router input port with NUM_VC virtual-channel FIFOs, a
// per-VC wormhole FSM (IDLE -> ROUTE -> ACTIVE) with XY routing, per-VC credit
// return and round-robin flit-level VC selection toward the switch.
// Optional build macro VCIU_STATS_EN adds a per-VC saturating 16-bit pop
// counter exported on flit_cnt.
module vc_input_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned VC_DEPTH = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned VCW      = 1
) (
  input  logic                clk0,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   cur_addr,
  input  logic [DATA_W-1:0]   in_flit,
  input  logic                in_val,
  input  logic [VCW-1:0]      in_vc,
  output logic [NUM_VC-1:0]   credit_out,
  output logic [DATA_W-1:0]   out_flit,
  output logic                out_val,
  output logic [VCW-1:0]      out_vc,
  output logic [4:0]          out_port,
  input  logic                out_gnt,
  output logic [NUM_VC-1:0]   err_ovf,
  output logic [NUM_VC-1:0]   err_proto
`ifdef VCIU_STATS_EN
  ,
  output logic [NUM_VC*16-1:0] flit_cnt
`endif
);

  localparam int unsigned PTRW = $clog2(VC_DEPTH);
  localparam int unsigned CW   = PTRW + 1;
  localparam int unsigned HALF = ADDR_W / 2;

  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b10;

  typedef enum logic [1:0] {VC_IDLE, VC_ROUTE, VC_ACTIVE} vc_state_e;

  logic [DATA_W-1:0] mem_q     [NUM_VC][VC_DEPTH];
  logic [DATA_W-1:0] mem_d     [NUM_VC][VC_DEPTH];
  logic [PTRW-1:0]   wr_ptr_q  [NUM_VC];
  logic [PTRW-1:0]   wr_ptr_d  [NUM_VC];
  logic [PTRW-1:0]   rd_ptr_q  [NUM_VC];
  logic [PTRW-1:0]   rd_ptr_d  [NUM_VC];
  logic [CW-1:0]     cnt_q     [NUM_VC];
  logic [CW-1:0]     cnt_d     [NUM_VC];
  vc_state_e         state_q   [NUM_VC];
  vc_state_e         state_d   [NUM_VC];
  logic [4:0]        route_q   [NUM_VC];
  logic [4:0]        route_d   [NUM_VC];
  logic [VCW-1:0]    rr_q, rr_d;
  logic [NUM_VC-1:0] credit_q, credit_d;
  logic [NUM_VC-1:0] err_ovf_q, err_ovf_d;
  logic [NUM_VC-1:0] err_proto_q, err_proto_d;

  logic [DATA_W-1:0] front      [NUM_VC];
  logic [1:0]        front_type [NUM_VC];
  logic [NUM_VC-1:0] empty, full, eligible;
  logic [NUM_VC-1:0] sw_pop, drop_pop, wr_hit, wr_ok;
  logic              sel_found;
  logic [VCW-1:0]    sel_vc;
  logic              vc_ok;

  function automatic logic [4:0] xy_route(input logic [ADDR_W-1:0] dst,
                                          input logic [ADDR_W-1:0] cur);
    logic [HALF-1:0] dx, dy, cx, cy;
    dx = dst[ADDR_W-1:HALF];
    dy = dst[HALF-1:0];
    cx = cur[ADDR_W-1:HALF];
    cy = cur[HALF-1:0];
    if (dx > cx)      return 5'b00010;
    else if (dx < cx) return 5'b00100;
    else if (dy > cy) return 5'b01000;
    else if (dy < cy) return 5'b10000;
    else              return 5'b00001;
  endfunction

  // FIFO front decode and per-VC status flags
  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      front[v]      = mem_q[v][rd_ptr_q[v]];
      front_type[v] = front[v][DATA_W-1:DATA_W-2];
      empty[v]      = (cnt_q[v] == '0);
      full[v]       = (cnt_q[v] == CW'(VC_DEPTH));
      eligible[v]   = (state_q[v] == VC_ACTIVE) && !empty[v];
    end
  end

  // Round-robin pick: first eligible VC at or after rr_q, else lowest eligible
  // (split into two passes so no modulo index is needed)
  always_comb begin
    sel_found = 1'b0;
    sel_vc    = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (!sel_found && eligible[v] && (v >= 32'(rr_q))) begin
        sel_found = 1'b1;
        sel_vc    = VCW'(v);
      end
    end
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (!sel_found && eligible[v]) begin
        sel_found = 1'b1;
        sel_vc    = VCW'(v);
      end
    end
  end

  // Pop and write qualification per VC
  always_comb begin
    vc_ok    = (32'(in_vc) < NUM_VC);
    sw_pop   = '0;
    drop_pop = '0;
    wr_hit   = '0;
    wr_ok    = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      sw_pop[v]   = sel_found && out_gnt && (sel_vc == VCW'(v));
      drop_pop[v] = (state_q[v] == VC_IDLE) && !empty[v] &&
                    ((front_type[v] == FT_BODY) || (front_type[v] == FT_TAIL));
      wr_hit[v]   = in_val && vc_ok && (in_vc == VCW'(v));
      wr_ok[v]    = wr_hit[v] && (!full[v] || sw_pop[v] || drop_pop[v]);
    end
  end

  // FIFO, VC FSM, arbitration pointer, credit and error next-state
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    route_d     = route_q;
    rr_d        = rr_q;
    credit_d    = sw_pop;
    err_ovf_d   = err_ovf_q;
    err_proto_d = err_proto_q;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (wr_hit[v] && !wr_ok[v]) err_ovf_d[v] = 1'b1;
      if (wr_ok[v]) begin
        mem_d[v][wr_ptr_q[v]] = in_flit;
        wr_ptr_d[v]           = wr_ptr_q[v] + 1'b1;
      end
      if (sw_pop[v] || drop_pop[v]) rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
      cnt_d[v] = cnt_q[v] + CW'(wr_ok[v]) - CW'(sw_pop[v] || drop_pop[v]);
      unique case (state_q[v])
        VC_IDLE: begin
          if (drop_pop[v])    err_proto_d[v] = 1'b1;
          else if (!empty[v]) state_d[v]     = VC_ROUTE;
        end
        VC_ROUTE: begin
          route_d[v] = xy_route(front[v][ADDR_W-1:0], cur_addr);
          state_d[v] = VC_ACTIVE;
        end
        VC_ACTIVE: begin
          // tail (10) and single (11) both carry bit 1 of the type field
          if (sw_pop[v] && front_type[v][1]) begin
            state_d[v] = VC_IDLE;
            route_d[v] = '0;
          end
        end
        default: state_d[v] = VC_IDLE;
      endcase
    end
    if (in_val && !vc_ok) err_ovf_d[0] = 1'b1;
    if (sel_found && out_gnt)
      rr_d = (32'(sel_vc) == NUM_VC - 1) ? '0 : sel_vc + 1'b1;
  end

  // Flit storage needs no reset: validity is tracked by the pointers
  always_ff @(posedge clk0) begin
    mem_q <= mem_d;
  end

  // Control state registers
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
        state_q[v]  <= VC_IDLE;
        route_q[v]  <= '0;
      end
      rr_q        <= '0;
      credit_q    <= '0;
      err_ovf_q   <= '0;
      err_proto_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      route_q     <= route_d;
      rr_q        <= rr_d;
      credit_q    <= credit_d;
      err_ovf_q   <= err_ovf_d;
      err_proto_q <= err_proto_d;
    end
  end

  // Switch-facing outputs
  always_comb begin
    out_val    = sel_found;
    out_flit   = sel_found ? front[sel_vc] : '0;
    out_vc     = sel_found ? sel_vc : '0;
    out_port   = sel_found ? route_q[sel_vc] : '0;
    credit_out = credit_q;
    err_ovf    = err_ovf_q;
    err_proto  = err_proto_q;
  end

`ifdef VCIU_STATS_EN
  logic [15:0] stat_q [NUM_VC];
  logic [15:0] stat_d [NUM_VC];

  // Saturating per-VC pop counters
  always_comb begin
    flit_cnt = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      stat_d[v] = stat_q[v];
      if (sw_pop[v] && (stat_q[v] != '1)) stat_d[v] = stat_q[v] + 16'd1;
      flit_cnt[16*v +: 16] = stat_q[v];
    end
  end

  // Counter registers
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      for (int unsigned v = 0; v < NUM_VC; v++) stat_q[v] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end
`endif

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit (default parameters, cur_addr = 8'h11).
module tb_vc_input_unit;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_VC   = 2;
  localparam int unsigned VC_DEPTH = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned VCW      = 1;

  logic              clk0 = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] in_flit;
  logic              in_val;
  logic [VCW-1:0]    in_vc;
  logic [NUM_VC-1:0] credit_out;
  logic [DATA_W-1:0] out_flit;
  logic              out_val;
  logic [VCW-1:0]    out_vc;
  logic [4:0]        out_port;
  logic              out_gnt;
  logic [NUM_VC-1:0] err_ovf;
  logic [NUM_VC-1:0] err_proto;
`ifdef VCIU_STATS_EN
  logic [NUM_VC*16-1:0] flit_cnt;
`endif

  vc_input_unit #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .VC_DEPTH(VC_DEPTH),
    .ADDR_W(ADDR_W), .VCW(VCW)
  ) dut (
    .clk0(clk0), .reset(reset), .cur_addr(cur_addr),
    .in_flit(in_flit), .in_val(in_val), .in_vc(in_vc),
    .credit_out(credit_out), .out_flit(out_flit), .out_val(out_val),
    .out_vc(out_vc), .out_port(out_port), .out_gnt(out_gnt),
    .err_ovf(err_ovf), .err_proto(err_proto)
`ifdef VCIU_STATS_EN
    , .flit_cnt(flit_cnt)
`endif
  );

  always #5 clk0 = ~clk0;

  int applied = 0;
  int miscompares = 0;

  logic [31:0] f, h0, b0, t0, h1, t1, oh, ob1, ob2, ot, ox;
  logic [7:0]  dsts  [5] = '{8'h21, 8'h01, 8'h12, 8'h10, 8'h11};
  logic [4:0]  ports [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [21:0] p,
                                     input logic [7:0] d);
    return {t, p, d};
  endfunction

  task automatic put(input logic [VCW-1:0] vc, input logic [31:0] fl);
    in_val  = 1'b1;
    in_vc   = vc;
    in_flit = fl;
  endtask

  initial begin
    reset = 1'b0; in_val = 1'b0; in_vc = '0; in_flit = '0;
    out_gnt = 1'b0; cur_addr = 8'h11;
    #2;
    chk("rst_out_val", out_val, 0);
    chk("rst_credit", credit_out, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_err_proto", err_proto, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_out_vc", out_vc, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Route sweep: single flits on VC0
    for (int i = 0; i < 5; i++) begin
      f = mk(2'b11, 22'(i + 1), dsts[i]);
      put(0, f); tick(); in_val = 1'b0;
      chk("sweep_lat_n", out_val, 0);
      tick();
      chk("sweep_lat_n1", out_val, 0);
      tick();
      chk("sweep_val", out_val, 1);
      chk("sweep_port", out_port, ports[i]);
      chk("sweep_flit", out_flit, f);
      chk("sweep_vc", out_vc, 0);
      out_gnt = 1'b1; tick(); out_gnt = 1'b0;
      chk("sweep_credit", credit_out, 2'b01);
      chk("sweep_idle", out_val, 0);
      tick();
      chk("sweep_credit_end", credit_out, 2'b00);
    end
`ifdef VCIU_STATS_EN
    chk("stats_after_sweep", flit_cnt, {16'd0, 16'd5});
`endif

    // Wormhole interleave, grant always on
    h0 = mk(2'b01, 22'h100, 8'h21); b0 = mk(2'b00, 22'h101, 8'h00);
    t0 = mk(2'b10, 22'h102, 8'h00); h1 = mk(2'b01, 22'h200, 8'h10);
    t1 = mk(2'b10, 22'h201, 8'h00);
    out_gnt = 1'b1;
    put(0, h0); tick();
    put(1, h1); tick();
    put(0, b0); tick();
    chk("wh1_vc", out_vc, 0); chk("wh1_flit", out_flit, h0);
    chk("wh1_port", out_port, 5'b00010); chk("wh1_credit", credit_out, 2'b00);
    put(1, t1); tick();
    chk("wh2_vc", out_vc, 1); chk("wh2_flit", out_flit, h1);
    chk("wh2_port", out_port, 5'b10000); chk("wh2_credit", credit_out, 2'b01);
    put(0, t0); tick(); in_val = 1'b0;
    chk("wh3_vc", out_vc, 0); chk("wh3_flit", out_flit, b0);
    chk("wh3_port", out_port, 5'b00010); chk("wh3_credit", credit_out, 2'b10);
    tick();
    chk("wh4_vc", out_vc, 1); chk("wh4_flit", out_flit, t1);
    chk("wh4_port", out_port, 5'b10000); chk("wh4_credit", credit_out, 2'b01);
    tick();
    chk("wh5_vc", out_vc, 0); chk("wh5_flit", out_flit, t0);
    chk("wh5_port", out_port, 5'b00010); chk("wh5_credit", credit_out, 2'b10);
    tick();
    chk("wh_end_val", out_val, 0); chk("wh_end_credit", credit_out, 2'b01);
    out_gnt = 1'b0;
    tick();

    // Backpressure on a 3-flit VC0 packet
    h0 = mk(2'b01, 22'h300, 8'h12); b0 = mk(2'b00, 22'h301, 8'h00);
    t0 = mk(2'b10, 22'h302, 8'h00);
    put(0, h0); tick();
    put(0, b0); tick();
    put(0, t0); tick(); in_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_flit", out_flit, h0);
      chk("bp_port", out_port, 5'b01000);
      chk("bp_credit", credit_out, 2'b00);
      tick();
    end
    out_gnt = 1'b1;
    chk("bp_hold_last", out_flit, h0);
    tick();
    chk("bp_pop1_credit", credit_out, 2'b01); chk("bp_pop1_flit", out_flit, b0);
    chk("bp_pop1_port", out_port, 5'b01000);
    tick();
    chk("bp_pop2_credit", credit_out, 2'b01); chk("bp_pop2_flit", out_flit, t0);
    tick();
    chk("bp_pop3_credit", credit_out, 2'b01); chk("bp_pop3_val", out_val, 0);
    out_gnt = 1'b0;
    tick();
    chk("bp_credit_end", credit_out, 2'b00);

    // Overflow: five writes into VC1 with the switch stalled
    oh  = mk(2'b01, 22'h400, 8'h11); ob1 = mk(2'b00, 22'h401, 8'h00);
    ob2 = mk(2'b00, 22'h402, 8'h00); ot  = mk(2'b10, 22'h403, 8'h00);
    ox  = mk(2'b11, 22'h404, 8'h21);
    put(1, oh);  tick();
    put(1, ob1); tick();
    put(1, ob2); tick();
    put(1, ot);  tick();
    chk("ovf_none_yet", err_ovf, 2'b00);
    put(1, ox);  tick(); in_val = 1'b0;
    chk("ovf_flag", err_ovf, 2'b10);
    chk("ovf_vc", out_vc, 1); chk("ovf_head", out_flit, oh);
    chk("ovf_port", out_port, 5'b00001);
    out_gnt = 1'b1;
    tick(); chk("ovf_drain1", out_flit, ob1);
    tick(); chk("ovf_drain2", out_flit, ob2);
    tick(); chk("ovf_drain3", out_flit, ot);
    tick(); chk("ovf_drained", out_val, 0);
    tick(); chk("ovf_no5th", out_val, 0);
    chk("ovf_no_proto", err_proto, 2'b00);
    out_gnt = 1'b0;
    tick();

    // Protocol error: body flit into idle VC0
    out_gnt = 1'b1;
    put(0, mk(2'b00, 22'h500, 8'h11)); tick(); in_val = 1'b0;
    chk("proto_noval1", out_val, 0);
    tick();
    chk("proto_flag", err_proto, 2'b01);
    chk("proto_noval2", out_val, 0);
    chk("proto_nocredit1", credit_out, 2'b00);
    tick();
    chk("proto_nocredit2", credit_out, 2'b00);
    out_gnt = 1'b0;
    f = mk(2'b11, 22'h501, 8'h21);
    put(0, f); tick(); in_val = 1'b0;
    tick(); tick();
    chk("proto_next_val", out_val, 1);
    chk("proto_next_port", out_port, 5'b00010);
    chk("proto_next_flit", out_flit, f);
    out_gnt = 1'b1; tick(); out_gnt = 1'b0;
    chk("proto_next_credit", credit_out, 2'b01);
    tick();

    // Asynchronous reset mid-packet
    put(0, mk(2'b01, 22'h600, 8'h01)); tick();
    put(0, mk(2'b00, 22'h601, 8'h00)); tick(); in_val = 1'b0;
    tick();
    chk("ar_pre_val", out_val, 1);
    chk("ar_pre_port", out_port, 5'b00100);
    chk("ar_pre_ovf", err_ovf, 2'b10);
    chk("ar_pre_proto", err_proto, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk("ar_val", out_val, 0);
    chk("ar_credit", credit_out, 2'b00);
    chk("ar_ovf", err_ovf, 2'b00);
    chk("ar_proto", err_proto, 2'b00);
    chk("ar_port", out_port, 5'b00000);
    chk("ar_flit", out_flit, 0);
`ifdef VCIU_STATS_EN
    chk("ar_stats", flit_cnt, 0);
`endif
    reset = 1'b1;
    tick();
    chk("ar_after_empty", out_val, 0);
    f = mk(2'b11, 22'h602, 8'h12);
    put(0, f); tick(); in_val = 1'b0;
    chk("ar_new_lat_n", out_val, 0);
    tick();
    chk("ar_new_lat_n1", out_val, 0);
    tick();
    chk("ar_new_val", out_val, 1);
    chk("ar_new_port", out_port, 5'b01000);
    chk("ar_new_flit", out_flit, f);
    out_gnt = 1'b1; tick(); out_gnt = 1'b0;
    chk("ar_new_credit", credit_out, 2'b01);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
